// File: rtl/coalesce_scatter.sv
// ============================================================================
// coalesce_scatter
//
// Response-side companion of the warp memory coalescer. One outstanding warp
// load is held at a time. For that load the block keeps the per-lane word
// offsets and the set of lanes that still wait for data. Returned memory
// segments arrive tagged with the lanes they serve. Each served lane copies
// its 32-bit word out of the segment. When no lane is left waiting, the
// assembled warp result is presented until the consumer takes it.
//
// Ports
//   clk        : clock
//   rst        : asynchronous active-high reset
//   req_valid  : new warp load request
//   req_ready  : block is idle and accepts a request (decoded from state)
//   req_addr   : lane i byte address at [i*SIZE_ADDR +: SIZE_ADDR]
//   req_mask   : active lanes of the request
//   seg_valid  : returned segment present
//   seg_ready  : segment consumed this cycle (decoded from state)
//   seg_mask   : lanes served by this segment
//   seg_data   : segment word k at [k*32 +: 32]
//   out_valid  : assembled warp result available (registered)
//   out_ready  : consumer takes the result
//   out_data   : lane i word at [i*32 +: 32] (registered)
//   out_mask   : captured request mask (registered)
//   seg_count  : segments consumed for the current request, saturating at 63
// ============================================================================
module coalesce_scatter #(
    parameter int SIZE_CORE              = 32,
    parameter int SIZE_ADDR              = 32,
    parameter int SIZE_SEGMENT_BYTES_LOG = 6
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              req_valid,
    output logic                                              req_ready,
    input  logic [SIZE_CORE*SIZE_ADDR-1:0]                    req_addr,
    input  logic [SIZE_CORE-1:0]                              req_mask,
    input  logic                                              seg_valid,
    output logic                                              seg_ready,
    input  logic [SIZE_CORE-1:0]                              seg_mask,
    input  logic [(1 << (SIZE_SEGMENT_BYTES_LOG - 2))*32-1:0] seg_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [SIZE_CORE*32-1:0]                           out_data,
    output logic [SIZE_CORE-1:0]                              out_mask,
    output logic [5:0]                                        seg_count
);

    // Word index width inside a segment and number of words per segment.
    localparam int WIDX      = SIZE_SEGMENT_BYTES_LOG - 2;
    localparam int SEG_WORDS = 1 << WIDX;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      state_next_s;

    // Only the word-select bits of each lane address matter; the segment base
    // is trusted to match the coalescer tag, so upper address bits are dropped.
    logic [SIZE_CORE*WIDX-1:0]   idx_r;
    logic [SIZE_CORE-1:0]        pending_r;
    logic [SIZE_CORE-1:0]        pending_next_s;
    logic [SIZE_CORE-1:0]        hit_s;
    logic                        seg_accept_s;
    logic [SIZE_CORE*32-1:0]     out_data_r;
    logic [SIZE_CORE-1:0]        out_mask_r;
    logic [5:0]                  seg_count_r;
    logic                        out_valid_r;

    logic [31:0]                 seg_words_s [SEG_WORDS];
    logic [31:0]                 lane_word_s [SIZE_CORE];
    logic                        unused_addr_s;

    // Address bits above the word index and the byte offset are not used.
    assign unused_addr_s = ^req_addr;

    // Split the segment bus into addressable 32-bit words.
    for (genvar k = 0; k < SEG_WORDS; k++) begin : g_seg_words
        assign seg_words_s[k] = seg_data[k*32 +: 32];
    end

    // Each lane picks its word by its stored index; several lanes may pick
    // the same word, which gives broadcast for free.
    for (genvar g = 0; g < SIZE_CORE; g++) begin : g_lane_sel
        assign lane_word_s[g] = seg_words_s[idx_r[g*WIDX +: WIDX]];
    end

    // Handshake strobes are decoded straight from the state register.
    assign req_ready    = (state_r == ST_IDLE);
    assign seg_ready    = (state_r == ST_COLLECT);
    assign seg_accept_s = (state_r == ST_COLLECT) && seg_valid;

    // Lanes filled by the segment consumed this cycle: only still-pending lanes.
    always_comb begin
        hit_s = {SIZE_CORE{1'b0}};
        if (seg_accept_s) begin
            hit_s = seg_mask & pending_r;
        end else begin
            hit_s = {SIZE_CORE{1'b0}};
        end
    end

    assign pending_next_s = pending_r & ~hit_s;

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_mask == {SIZE_CORE{1'b0}}) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_COLLECT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                // Completion is judged on the post-update pending set.
                if (seg_accept_s && (pending_next_s == {SIZE_CORE{1'b0}})) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // out_valid is registered from the next state so it rises together with
    // the DONE state and drops together with the return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_next_s == ST_DONE);
        end
    end

    // Request capture, lane scatter, pending tracking and segment counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r       <= {(SIZE_CORE*WIDX){1'b0}};
            pending_r   <= {SIZE_CORE{1'b0}};
            out_data_r  <= {(SIZE_CORE*32){1'b0}};
            out_mask_r  <= {SIZE_CORE{1'b0}};
            seg_count_r <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Lanes that are never served must read back as zero.
                    out_data_r <= {(SIZE_CORE*32){1'b0}};
                    if (req_valid) begin
                        for (int i = 0; i < SIZE_CORE; i++) begin
                            idx_r[i*WIDX +: WIDX] <= req_addr[i*SIZE_ADDR + 2 +: WIDX];
                        end
                        out_mask_r  <= req_mask;
                        pending_r   <= req_mask;
                        seg_count_r <= 6'd0;
                    end else begin
                        pending_r   <= pending_r;
                    end
                end
                ST_COLLECT: begin
                    if (seg_accept_s) begin
                        for (int i = 0; i < SIZE_CORE; i++) begin
                            if (hit_s[i]) begin
                                out_data_r[i*32 +: 32] <= lane_word_s[i];
                            end else begin
                                out_data_r[i*32 +: 32] <= out_data_r[i*32 +: 32];
                            end
                        end
                        pending_r <= pending_next_s;
                        // Every consumed segment counts, even one that hits no lane.
                        if (seg_count_r != 6'd63) begin
                            seg_count_r <= seg_count_r + 6'd1;
                        end else begin
                            seg_count_r <= seg_count_r;
                        end
                    end else begin
                        pending_r <= pending_r;
                    end
                end
                ST_DONE: begin
                    // Result is frozen until the consumer takes it.
                    pending_r <= pending_r;
                end
                default: begin
                    pending_r <= {SIZE_CORE{1'b0}};
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_mask  = out_mask_r;
    assign seg_count = seg_count_r;

endmodule
